// File: rtl/axi_cmd_arbiter_if.sv
// Command-side bundle between the requesters, the arbiter and the AXI master.
// The arbiter uses the slave view; the requester/master environment uses the master view.
interface axi_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ*2-1:0]      req_burst;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_wr;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [LEN_W-1:0]          cmd_len;
  logic [1:0]                cmd_burst;
  logic [ID_W-1:0]           cmd_id;

  logic                      done_valid;
  logic [1:0]                done_resp;
  logic [NUM_REQ-1:0]        cpl_valid;
  logic [1:0]                cpl_resp;

  logic                      busy;
  logic                      timeout_err;

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, req_burst,
    output req_ready,
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_burst, cmd_id,
    input  cmd_ready,
    input  done_valid, done_resp,
    output cpl_valid, cpl_resp,
    output busy, timeout_err
  );

  modport master (
    output req_valid, req_wr, req_addr, req_len, req_burst,
    input  req_ready,
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_burst, cmd_id,
    output cmd_ready,
    output done_valid, done_resp,
    input  cpl_valid, cpl_resp,
    input  busy, timeout_err
  );
endinterface

// File: rtl/axi_cmd_arbiter.sv
// Round-robin command arbiter in front of a single-outstanding AXI master.
// Optional watchdog enabled by defining AXI_CMD_ARB_TIMEOUT_EN.
module axi_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  axi_cmd_arbiter_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2**ID_W) < NUM_REQ || TIMEOUT < 2) begin : g_param_check
    $error("axi_cmd_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     cmd_id_q, cmd_id_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  cpl_valid_q, cpl_valid_d;
  logic [1:0]          cpl_resp_q, cpl_resp_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
  logic [1:0]          cmd_burst_q, cmd_burst_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     next_ptr;
  logic                expired;

`ifdef AXI_CMD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign expired = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  // Counter restarts on every state change, so ISSUE and WAIT_DONE each get a full budget
  always_comb begin
    tmo_cnt_d = '0;
    if (state_d == state_q && state_q != IDLE) tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) tmo_cnt_q <= '0;
    else                tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign expired = 1'b0;
`endif

  // Search rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first pending requester wins
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  assign next_ptr = (cmd_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cmd_id_q + ID_W'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cmd_id_d      = cmd_id_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    cmd_burst_d   = cmd_burst_q;
    cpl_resp_d    = cpl_resp_q;
    req_ready_d   = '0;
    cpl_valid_d   = '0;
    timeout_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cmd_id_d    = grant_idx;
          cmd_wr_d    = bus.req_wr[grant_idx];
          cmd_addr_d  = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          cmd_len_d   = bus.req_len[int'(grant_idx)*LEN_W +: LEN_W];
          cmd_burst_d = bus.req_burst[int'(grant_idx)*2 +: 2];
          req_ready_d = NUM_REQ'(1) << grant_idx;
          cmd_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_valid_q && bus.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_DONE;
        end else if (expired) begin
          cmd_valid_d   = 1'b0;
          cpl_valid_d   = NUM_REQ'(1) << cmd_id_q;
          cpl_resp_d    = 2'b10;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.done_valid) begin
          cpl_valid_d = NUM_REQ'(1) << cmd_id_q;
          cpl_resp_d  = bus.done_resp;
          rr_ptr_d    = next_ptr;
          state_d     = IDLE;
        end else if (expired) begin
          cpl_valid_d   = NUM_REQ'(1) << cmd_id_q;
          cpl_resp_d    = 2'b10;
          timeout_err_d = 1'b1;
          rr_ptr_d      = next_ptr;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Reset clears the command fields too, so a dropped command leaves nothing visible
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cmd_id_q      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_wr_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      cmd_burst_q   <= '0;
      req_ready_q   <= '0;
      cpl_valid_q   <= '0;
      cpl_resp_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cmd_id_q      <= cmd_id_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      cmd_burst_q   <= cmd_burst_d;
      req_ready_q   <= req_ready_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_resp_q    <= cpl_resp_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_wr      = cmd_wr_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.cmd_len     = cmd_len_q;
  assign bus.cmd_burst   = cmd_burst_q;
  assign bus.cmd_id      = cmd_id_q;
  assign bus.cpl_valid   = cpl_valid_q;
  assign bus.cpl_resp    = cpl_resp_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed plus randomized bench for axi_cmd_arbiter against a transaction-level reference model.
module tb_axi_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int AW   = 24;
  localparam int LW   = 8;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  axi_cmd_arbiter_if #(.NUM_REQ(NREQ), .ID_W(IDW), .ADDR_W(AW), .LEN_W(LW)) bus ();

  axi_cmd_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rstn),
    .bus           (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a command is one transaction (grant, accept, done) owned by one requester
  int            m_phase;   // 0 = no command, 1 = offered downstream, 2 = awaiting completion
  int            m_rr, m_owner, m_cnt;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [1:0]    m_burst, m_resp;
  logic [NREQ-1:0] e_req_ready, e_cpl;
  logic          e_cmd_valid, e_busy, e_tmo, m_rst;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit watchdog_hit();
`ifdef AXI_CMD_ARB_TIMEOUT_EN
    return (m_cnt == TMO - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_finish(input logic [1:0] resp, input logic tmo);
    e_cpl       = NREQ'(1) << m_owner;
    m_resp      = resp;
    e_tmo       = tmo;
    m_rr        = (m_owner + 1) % NREQ;
    m_phase     = 0;
    e_cmd_valid = 1'b0;
  endtask

  // Applies the inputs currently driven at the coming edge to the transaction model
  task automatic model_edge();
    int w;
    e_req_ready = '0;
    e_cpl       = '0;
    e_tmo       = 1'b0;
    m_rst       = 1'b0;
    if (!rstn) begin
      m_phase = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
      m_wr = 1'b0; m_addr = '0; m_len = '0; m_burst = '0; m_resp = '0;
      e_cmd_valid = 1'b0; e_busy = 1'b0; m_rst = 1'b1;
      return;
    end
    case (m_phase)
      0: begin
        w = -1;
        for (int off = 0; off < NREQ; off++)
          if (w < 0 && bus.req_valid[(m_rr + off) % NREQ]) w = (m_rr + off) % NREQ;
        if (w >= 0) begin
          m_owner     = w;
          m_wr        = bus.req_wr[w];
          m_addr      = bus.req_addr[w*AW +: AW];
          m_len       = bus.req_len[w*LW +: LW];
          m_burst     = bus.req_burst[w*2 +: 2];
          e_req_ready = NREQ'(1) << w;
          e_cmd_valid = 1'b1;
          m_phase     = 1;
          m_cnt       = 0;
        end
      end
      1: begin
        if (bus.cmd_ready) begin
          e_cmd_valid = 1'b0;
          m_phase     = 2;
          m_cnt       = 0;
        end else if (watchdog_hit()) model_finish(2'b10, 1'b1);
        else m_cnt++;
      end
      default: begin
        if (bus.done_valid) model_finish(bus.done_resp, 1'b0);
        else if (watchdog_hit()) model_finish(2'b10, 1'b1);
        else m_cnt++;
      end
    endcase
    e_busy = (m_phase != 0);
  endtask

  task automatic compare_all();
    chk("req_ready", bus.req_ready, e_req_ready);
    chk("cmd_valid", bus.cmd_valid, e_cmd_valid);
    chk("busy", bus.busy, e_busy);
    chk("cpl_valid", bus.cpl_valid, e_cpl);
    chk("timeout_err", bus.timeout_err, e_tmo);
    if (e_busy || m_rst) begin
      chk("cmd_id", bus.cmd_id, m_owner);
      chk("cmd_wr", bus.cmd_wr, m_wr);
      chk("cmd_addr", bus.cmd_addr, m_addr);
      chk("cmd_len", bus.cmd_len, m_len);
      chk("cmd_burst", bus.cmd_burst, m_burst);
    end
    if (e_cpl != '0 || m_rst) chk("cpl_resp", bus.cpl_resp, m_resp);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_fields(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input logic [1:0] b);
    bus.req_wr[i]            = wr;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_len[i*LW +: LW]  = l;
    bus.req_burst[i*2 +: 2]  = b;
  endtask

  task automatic rand_fields(input int i);
    set_fields(i, 1'($urandom), AW'($urandom), LW'($urandom), 2'($urandom));
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0;
    bus.cmd_ready  = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_resp  = 2'b00;
  endtask

  task automatic finish_cmd(input logic [1:0] resp);
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready  = 1'b0;
    bus.done_valid = 1'b1;
    bus.done_resp  = resp;
    step();
    bus.done_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  int grants[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rstn = 1'b0;
    clear_inputs();
    bus.req_wr = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_burst = '0;

    do_reset();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cmd_valid", bus.cmd_valid, 1'b0);

    // Single request from requester 1, then check rr_ptr moved to 2
    set_fields(1, 1'b1, 24'h000100, 8'd3, 2'd1);
    bus.req_valid = 4'b0010;
    step();
    chk("sr_req_ready", bus.req_ready, 4'b0010);
    chk("sr_cmd_id", bus.cmd_id, 2'd1);
    chk("sr_cmd_addr", bus.cmd_addr, 24'h000100);
    chk("sr_cmd_len", bus.cmd_len, 8'd3);
    bus.req_valid = 4'b0000;
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready  = 1'b0;
    bus.done_valid = 1'b1;
    bus.done_resp  = 2'b00;
    step();
    chk("sr_cpl_valid", bus.cpl_valid, 4'b0010);
    chk("sr_cpl_resp", bus.cpl_resp, 2'b00);
    bus.done_valid = 1'b0;
    set_fields(0, 1'b0, 24'h000200, 8'd0, 2'd1);
    set_fields(2, 1'b0, 24'h000300, 8'd1, 2'd1);
    bus.req_valid = 4'b0111;
    step();
    chk("sr_rr_next", bus.cmd_id, 2'd2);
    bus.req_valid = 4'b0000;
    finish_cmd(2'b00);

    // Fairness with every requester pending and an always-ready master
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_fields(i);
    bus.req_valid  = 4'b1111;
    bus.cmd_ready  = 1'b1;
    bus.done_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) grants.push_back(i);
    end
    chk("fair_count", grants.size() >= 5, 1'b1);
    for (int i = 0; i < 5; i++)
      chk("fair_order", (i < grants.size()) ? grants[i] : 99, exp_order[i]);
    clear_inputs();
    do_reset();

    // Backpressure: command must stay frozen while cmd_ready is low
    set_fields(0, 1'b1, 24'hABCDEF, 8'd15, 2'd2);
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_cmd_valid", bus.cmd_valid, 1'b1);
      chk("bp_cmd_addr", bus.cmd_addr, 24'hABCDEF);
      chk("bp_req_ready", bus.req_ready, 4'b0000);
      chk("bp_busy", bus.busy, 1'b1);
    end
    finish_cmd(2'b00);

    // Error response passes through to requester 3
    set_fields(3, 1'b0, 24'h123456, 8'd7, 2'd1);
    bus.req_valid = 4'b1000;
    step();
    bus.req_valid = 4'b0000;
    finish_cmd(2'b11);
    chk("err_cpl_valid", bus.cpl_valid, 4'b1000);
    chk("err_cpl_resp", bus.cpl_resp, 2'b11);

`ifdef AXI_CMD_ARB_TIMEOUT_EN
    // Watchdog expiry in WAIT_DONE, then a completion on the expiry cycle
    for (int rep = 0; rep < 2; rep++) begin
      set_fields(0, 1'b1, 24'h00F000, 8'd1, 2'd1);
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = 4'b0000;
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      for (int c = 0; c < TMO - 1; c++) step();
      bus.done_valid = (rep == 1);
      bus.done_resp  = 2'b01;
      step();
      bus.done_valid = 1'b0;
      chk("tmo_err", bus.timeout_err, (rep == 0));
      chk("tmo_resp", bus.cpl_resp, (rep == 0) ? 2'b10 : 2'b01);
      chk("tmo_cpl", bus.cpl_valid, 4'b0001);
      step();
      chk("tmo_idle", bus.busy, 1'b0);
    end
`endif

    // Reset while waiting for completion drops the command; rr_ptr returns to 0
    set_fields(1, 1'b1, 24'h0000AA, 8'd2, 2'd1);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b0000;
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready  = 1'b0;
    bus.done_valid = 1'b1;
    rstn = 1'b0;
    step();
    chk("rmid_busy", bus.busy, 1'b0);
    chk("rmid_cpl", bus.cpl_valid, 4'b0000);
    rstn = 1'b1;
    bus.done_valid = 1'b0;
    set_fields(2, 1'b0, 24'h0000BB, 8'd4, 2'd0);
    set_fields(3, 1'b1, 24'h0000CC, 8'd5, 2'd2);
    bus.req_valid = 4'b1100;
    step();
    chk("rmid_grant", bus.cmd_id, 2'd2);
    bus.req_valid[2] = 1'b0;

    // Randomized traffic obeying the requester contract
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req_valid[i] = 1'b0;
          else rand_fields(i);
        end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          rand_fields(i);
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.cmd_ready  = ($urandom_range(0, 2) != 0);
      bus.done_valid = ($urandom_range(0, 2) != 0);
      bus.done_resp  = 2'($urandom);
      rstn           = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_cmd_arbiter.md
Name: axi_cmd_arbiter

Overview:
- Round-robin scheduler that shares the single command interface of the AXI full master (wr, addr, burst len, burst type) among NUM_REQ requesters.
- Grants one requester, presents its command downstream with a valid/ready handshake, then holds the interface until the master reports completion.
- Routes the response back to the owning requester as a one-hot completion pulse.
- Sits between client engines (DMA, register bridge, test sequencer) and the AXI master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of cmd_id; must satisfy 2**ID_W >= NUM_REQ.
- ADDR_W, 24, command address width.
- LEN_W, 8, burst length width (AXI awlen/arlen encoding).
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_aresetn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester command request.
- req_wr  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_len  in  NUM_REQ*LEN_W  packed burst lengths.
- req_burst  in  NUM_REQ*2  packed burst types.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- cmd_valid  out  1  downstream command valid.
- cmd_ready  in  1  downstream accept.
- cmd_wr, cmd_addr, cmd_len, cmd_burst  out  1/ADDR_W/LEN_W/2  latched command fields.
- cmd_id  out  ID_W  index of the owning requester.
- done_valid  in  1  master completion pulse.
- done_resp  in  2  master response.
- cpl_valid  out  NUM_REQ  one-hot completion pulse.
- cpl_resp  out  2  response qualified by cpl_valid.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- All outputs are registered.
- Reset (m_axi_aresetn=0 at a clock edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0; cmd_* fields 0.
  - An in-flight command is dropped silently; no cpl_valid is issued for it.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE, when any req_valid is high at edge N:
  - Winner = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - The winner's fields are latched into cmd_*, and cmd_id=winner.
  - From N+1: req_ready[winner]=1 for exactly one cycle, cmd_valid=1, busy=1; state goes to ISSUE.
  - With no request, the block stays in IDLE and all pulses are 0.
- ISSUE:
  - cmd_valid and cmd_* stay stable until cmd_ready.
  - On the cmd_valid && cmd_ready edge: cmd_valid=0 next cycle, go to WAIT_DONE.
  - done_valid is ignored in ISSUE.
- WAIT_DONE, on done_valid:
  - Next cycle: cpl_valid[cmd_id]=1 for one cycle, cpl_resp=done_resp.
  - rr_ptr = (cmd_id+1) mod NUM_REQ; state goes to IDLE; busy=0.
  - Earliest re-arbitration is the cycle after the cpl pulse. Back-to-back commands therefore take 3 cycles minimum when cmd_ready and done_valid are immediate.
- Requester contract:
  - Hold req_valid and fields stable until req_ready is seen.
  - Deassert req_valid on the cycle after req_ready, unless issuing a new command.
  - Fields are sampled only at the grant edge.
- req_valid changes during ISSUE or WAIT_DONE have no effect.
- Only one command is outstanding at a time. cmd_id is therefore informational and is not reordered.

Optional Feature:
- Macro: AXI_CMD_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in ISSUE and WAIT_DONE. It clears on entry to each state and increments every cycle.
  - When it reaches TIMEOUT-1 without the exit condition: next cycle cmd_valid=0, cpl_valid[cmd_id]=1, cpl_resp=2'b10 (SLVERR), timeout_err=1 (one cycle); rr_ptr advances and the block returns to IDLE.
  - If done_valid (or cmd_ready in ISSUE) coincides with expiry, the normal path wins and timeout_err stays 0.
- Undefined:
  - No counter; the block waits indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Single request: req_valid=4'b0010, wr=1, addr=24'h000100, len=3, burst=1; cmd_ready and done_valid (resp=0) each one cycle later -> req_ready=4'b0010 at N+1; cmd_id=1, cmd_addr=24'h000100, cmd_len=3; cpl_valid=4'b0010, cpl_resp=0; rr_ptr=2.
- Fairness: all four req_valid held high, immediate cmd_ready and done_valid -> grant order 0,1,2,3,0; each cpl_valid is one-hot in the matching order.
- Backpressure: cmd_ready held low 10 cycles -> cmd_valid and all cmd_* stable for 10 cycles; no second req_ready; busy=1 throughout.
- Error pass-through: done_resp=2'b11 on a read from requester 3 -> cpl_valid=4'b1000, cpl_resp=2'b11.
- Reset mid-operation: reset asserted in WAIT_DONE -> next cycle all outputs 0, busy=0; no cpl pulse; the next grant with requesters 2 and 3 pending goes to requester 2, because rr_ptr=0 and the search order is 0, 1, 2.
- Timeout (AXI_CMD_ARB_TIMEOUT_EN, TIMEOUT=64): done_valid withheld -> 64 cycles after WAIT_DONE entry, cpl_resp=2'b10 and timeout_err=1 for one cycle, then IDLE. Repeat with done_valid arriving on the expiry cycle -> normal completion, timeout_err=0.
